// File: rtl/tmnt_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
//   NUM_KEYS_C  : number of push-button keys (note code = key index)
//   note_t      : 4-bit note code
//   voice_idx_t : voice index (up to 8 voices)
//   key_ev_t    : per-scan-slot key event
package tmnt_pkg;
  localparam int NUM_KEYS_C = 15;

  typedef logic [3:0] note_t;
  typedef logic [2:0] voice_idx_t;

  typedef enum logic [1:0] {EV_NONE, EV_PRESS, EV_RELEASE} key_ev_t;
endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice age bookkeeping for the voice allocator.
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   active     : current voice-active mask
//   alloc      : strobe, voice alloc_idx is being (re)assigned this cycle
//   alloc_idx  : voice being (re)assigned
//   free_idx   : lowest-index inactive voice
//   steal_idx  : voice with the highest age, ties to the lowest index
//   all_busy   : no inactive voice exists
module voice_age_tracker
  import tmnt_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NUM_VOICES-1:0] active,
  input  logic                  alloc,
  input  voice_idx_t            alloc_idx,
  output voice_idx_t            free_idx,
  output voice_idx_t            steal_idx,
  output logic                  all_busy
);
  typedef logic [2:0] age_t;
  localparam age_t AGE_MAX = age_t'(NUM_VOICES - 1);

  age_t age [NUM_VOICES];
  age_t oldest;
  age_t gap;
  age_t old_age;
  logic taken;

  always_comb begin
    free_idx = '0;
    all_busy = 1'b1;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        free_idx = voice_idx_t'(v);
        all_busy = 1'b0;
      end
    end

    steal_idx = '0;
    oldest    = age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > oldest) begin
        oldest    = age[v];
        steal_idx = voice_idx_t'(v);
      end
    end

    // A free voice is ranked into the lowest age value no active voice
    // holds, so active ages stay distinct and ordered by allocation time
    // (pure LRU) even after releases leave holes in the sequence.
    gap   = AGE_MAX;
    taken = 1'b0;
    for (int a = NUM_VOICES - 1; a >= 0; a--) begin
      taken = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (active[v] && age[v] == age_t'(a)) taken = 1'b1;
      end
      if (!taken) gap = age_t'(a);
    end

    old_age = gap;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (alloc_idx == voice_idx_t'(v) && active[v]) old_age = age[v];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
    end else if (alloc) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (alloc_idx == voice_idx_t'(v)) begin
          age[v] <= '0;
        end else if (active[v] && age[v] < old_age && age[v] < AGE_MAX) begin
          age[v] <= age[v] + age_t'(1);
        end
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: scans the keys one slot per scan tick, turns
// press/release edges into voice assignments, steals the oldest voice when
// all are busy, and drives per-voice enable/note/retrigger.
// Optional feature macro: TMNT_SUSTAIN_EN (adds the sustain pedal input).
// Ports:
//   clk, nrst    : clock, asynchronous active-low reset
//   scan_en      : scanner advances one key per cycle while high
//   keys         : debounced key levels, 1 = pressed
//   sustain      : sustain pedal (TMNT_SUSTAIN_EN only)
//   voice_active : voice i sounding
//   voice_note   : note of voice i at [4i+3:4i]
//   voice_trig   : one-cycle pulse when voice i is (re)assigned
//   scan_idx     : key slot currently sampled
module voice_allocator
  import tmnt_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_C,
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    scan_en,
  input  logic [NUM_KEYS-1:0]     keys,
`ifdef TMNT_SUSTAIN_EN
  input  logic                    sustain,
`endif
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [4*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [3:0]              scan_idx
);
  logic [NUM_KEYS-1:0]   prev_keys;
  logic [NUM_VOICES-1:0] sus_flag;
  logic [NUM_VOICES-1:0] act_eff;
  logic                  sus_now;
  logic                  sus_fall;
  key_ev_t               ev;
  logic                  hit_any;
  logic                  hit_sus;
  voice_idx_t            hit_idx;
  logic                  alloc;
  voice_idx_t            alloc_idx;
  voice_idx_t            free_idx;
  voice_idx_t            steal_idx;
  logic                  all_busy;

`ifdef TMNT_SUSTAIN_EN
  logic sus_q;
  assign sus_now  = sustain;
  assign sus_fall = sus_q & ~sustain;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sus_q    <= 1'b0;
      sus_flag <= '0;
    end else begin
      sus_q <= sustain;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (sus_fall) sus_flag[v] <= 1'b0;
        if (ev == EV_RELEASE && hit_any && sustain && hit_idx == voice_idx_t'(v))
          sus_flag[v] <= 1'b1;
        if (alloc && alloc_idx == voice_idx_t'(v)) sus_flag[v] <= 1'b0;
      end
    end
  end
`else
  assign sus_now  = 1'b0;
  assign sus_fall = 1'b0;
  assign sus_flag = '0;
`endif

  // Sustained voices released by a pedal-up are freed before this cycle's
  // key event is decided, so a press in the same cycle may reuse them.
  assign act_eff = voice_active & ~(sus_fall ? sus_flag : '0);

  always_comb begin
    ev = EV_NONE;
    if (scan_en) begin
      if (keys[scan_idx] && !prev_keys[scan_idx])      ev = EV_PRESS;
      else if (!keys[scan_idx] && prev_keys[scan_idx]) ev = EV_RELEASE;
    end

    hit_any = 1'b0;
    hit_sus = 1'b0;
    hit_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (act_eff[v] && voice_note[4*v +: 4] == scan_idx) begin
        hit_any = 1'b1;
        hit_sus = sus_flag[v];
        hit_idx = voice_idx_t'(v);
      end
    end

    alloc = (ev == EV_PRESS);
    if (hit_any && hit_sus) alloc_idx = hit_idx;   // re-press of a sustained note
    else if (all_busy)      alloc_idx = steal_idx;
    else                    alloc_idx = free_idx;
  end

  voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
    .clk       (clk),
    .nrst      (nrst),
    .active    (act_eff),
    .alloc     (alloc),
    .alloc_idx (alloc_idx),
    .free_idx  (free_idx),
    .steal_idx (steal_idx),
    .all_busy  (all_busy)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scan_idx     <= '0;
      prev_keys    <= '0;
      voice_active <= '0;
      voice_note   <= '0;
      voice_trig   <= '0;
    end else begin
      voice_trig   <= '0;
      voice_active <= act_eff;
      if (scan_en) begin
        prev_keys[scan_idx] <= keys[scan_idx];
        scan_idx <= (scan_idx == 4'(NUM_KEYS - 1)) ? 4'd0 : scan_idx + 4'd1;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ev == EV_RELEASE && hit_any && !sus_now && hit_idx == voice_idx_t'(v))
          voice_active[v] <= 1'b0;
        if (alloc && alloc_idx == voice_idx_t'(v)) begin
          voice_active[v]       <= 1'b1;
          voice_note[4*v +: 4]  <= scan_idx;
          voice_trig[v]         <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus a
// randomized run, all compared against an LRU reference model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int NK = 15;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            scan_en = 1'b0;
  logic [NK-1:0]   keys = '0;
  logic            sus = 1'b0;
  logic [NV-1:0]   voice_active;
  logic [4*NV-1:0] voice_note;
  logic [NV-1:0]   voice_trig;
  logic [3:0]      scan_idx;

  int n_tests = 0;
  int n_fail  = 0;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .scan_en      (scan_en),
    .keys         (keys),
`ifdef TMNT_SUSTAIN_EN
    .sustain      (sus),
`endif
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .voice_trig   (voice_trig),
    .scan_idx     (scan_idx)
  );

  always #5 clk = ~clk;

  // Reference model: voices remember when they were last assigned; the
  // steal victim is the active voice assigned longest ago.
  bit          m_act   [NV];
  int          m_note  [NV];
  int          m_time  [NV];
  bit          m_sflag [NV];
  bit          m_trig  [NV];
  bit [NK-1:0] m_prev;
  int          m_scan;
  int          m_clk;
  bit          m_sprev;
  logic [NV-1:0]   exp_active = '0;
  logic [4*NV-1:0] exp_note = '0;
  logic [NV-1:0]   exp_trig = '0;
  logic [3:0]      exp_scan = '0;

  always @(posedge clk or negedge nrst) begin
    int k, tgt;
    bit cur;
    if (!nrst) begin
      for (int v = 0; v < NV; v++) begin
        m_act[v] = 0; m_note[v] = 0; m_time[v] = 0; m_sflag[v] = 0; m_trig[v] = 0;
      end
      m_prev = '0; m_scan = 0; m_clk = 0; m_sprev = 0;
    end else begin
      m_clk++;
      for (int v = 0; v < NV; v++) m_trig[v] = 0;
`ifdef TMNT_SUSTAIN_EN
      if (m_sprev && !sus)
        for (int v = 0; v < NV; v++)
          if (m_sflag[v]) begin m_act[v] = 0; m_sflag[v] = 0; end
      m_sprev = sus;
`endif
      if (scan_en) begin
        k = m_scan;
        cur = keys[k];
        if (cur && !m_prev[k]) begin
          tgt = -1;
`ifdef TMNT_SUSTAIN_EN
          for (int v = 0; v < NV; v++)
            if (m_act[v] && m_sflag[v] && m_note[v] == k) tgt = v;
`endif
          if (tgt < 0)
            for (int v = NV - 1; v >= 0; v--) if (!m_act[v]) tgt = v;
          if (tgt < 0) begin
            tgt = 0;
            for (int v = 1; v < NV; v++) if (m_time[v] < m_time[tgt]) tgt = v;
          end
          m_act[tgt] = 1; m_note[tgt] = k; m_time[tgt] = m_clk;
          m_trig[tgt] = 1; m_sflag[tgt] = 0;
        end else if (!cur && m_prev[k]) begin
          for (int v = 0; v < NV; v++)
            if (m_act[v] && m_note[v] == k) begin
              if (sus) m_sflag[v] = 1;
              else     m_act[v] = 0;
            end
        end
        m_prev[k] = cur;
        m_scan = (k == NK - 1) ? 0 : k + 1;
      end
    end
    for (int v = 0; v < NV; v++) begin
      exp_active[v]     = m_act[v];
      exp_note[4*v +: 4] = 4'(m_note[v]);
      exp_trig[v]       = m_trig[v];
    end
    exp_scan = 4'(m_scan);
  end

  task automatic test_reset;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({voice_active, voice_note, voice_trig, scan_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset: act=%b note=%h trig=%b scan=%0d, want all zero",
               voice_active, voice_note, voice_trig, scan_idx);
    end
    nrst = 1'b1;
  endtask

  task automatic test_single_press;
    int pulses = 0;
    scan_en = 1'b1;
    keys[5] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_tests++;
      if ({voice_active, voice_note, voice_trig, scan_idx} !== {exp_active, exp_note, exp_trig, exp_scan}) begin
        n_fail++;
        $display("FAIL single_press c%0d: act=%b note=%h trig=%b scan=%0d want act=%b note=%h trig=%b scan=%0d",
                 c, voice_active, voice_note, voice_trig, scan_idx, exp_active, exp_note, exp_trig, exp_scan);
      end
      if (voice_trig[0]) pulses++;
    end
    n_tests++;
    if (voice_active !== 4'b0001 || voice_note[3:0] !== 4'd5 || pulses != 1) begin
      n_fail++;
      $display("FAIL single_press_final: act=%b note0=%0d pulses=%0d want act=0001 note0=5 pulses=1",
               voice_active, voice_note[3:0], pulses);
    end
  endtask

  task automatic test_steal;
    int pulses = 0;
    keys = '0;
    for (int n = 0; n <= 5; n++) begin
      if (n >= 1 && n <= 4) keys[n] = 1'b1;
      if (n == 5) keys[9] = 1'b1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        n_tests++;
        if ({voice_active, voice_note, voice_trig, scan_idx} !== {exp_active, exp_note, exp_trig, exp_scan}) begin
          n_fail++;
          $display("FAIL steal n%0d c%0d: act=%b note=%h trig=%b scan=%0d want act=%b note=%h trig=%b scan=%0d",
                   n, c, voice_active, voice_note, voice_trig, scan_idx, exp_active, exp_note, exp_trig, exp_scan);
        end
        if (n == 5 && voice_trig[0]) pulses++;
      end
      if (n == 4) begin
        n_tests++;
        if (voice_active !== 4'b1111 || voice_note !== 16'h4321) begin
          n_fail++;
          $display("FAIL fill_four: act=%b note=%h want act=1111 note=4321", voice_active, voice_note);
        end
      end
    end
    n_tests++;
    if (voice_active !== 4'b1111 || voice_note !== 16'h4329 || pulses != 1) begin
      n_fail++;
      $display("FAIL steal_oldest: act=%b note=%h pulses=%0d want act=1111 note=4329 pulses=1",
               voice_active, voice_note, pulses);
    end
  endtask

  task automatic test_release;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) keys[1] = 1'b0;
      if (n == 1) keys[3] = 1'b0;
      if (n == 2) keys[7] = 1'b1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        n_tests++;
        if ({voice_active, voice_note, voice_trig, scan_idx} !== {exp_active, exp_note, exp_trig, exp_scan}) begin
          n_fail++;
          $display("FAIL release n%0d c%0d: act=%b note=%h trig=%b scan=%0d want act=%b note=%h trig=%b scan=%0d",
                   n, c, voice_active, voice_note, voice_trig, scan_idx, exp_active, exp_note, exp_trig, exp_scan);
        end
      end
      n_tests++;
      if ((n == 0 && voice_active !== 4'b1111) ||
          (n == 1 && voice_active !== 4'b1011) ||
          (n == 2 && (voice_active !== 4'b1111 || voice_note[11:8] !== 4'd7))) begin
        n_fail++;
        $display("FAIL release_step%0d: act=%b note=%h", n, voice_active, voice_note);
      end
    end
  endtask

  task automatic test_scan_hold;
    logic [4*NV+2*NV+4-1:0] frozen;
    int idx;
    @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    frozen = {exp_active, exp_note, exp_trig, exp_scan};
    for (int c = 0; c < 40; c++) begin
      idx = $urandom_range(0, NK - 1);
      keys[idx] = ~keys[idx];
      @(negedge clk);
      n_tests++;
      if ({voice_active, voice_note, voice_trig, scan_idx} !== frozen) begin
        n_fail++;
        $display("FAIL scan_hold c%0d: got %h want %h", c,
                 {voice_active, voice_note, voice_trig, scan_idx}, frozen);
      end
    end
    scan_en = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_tests++;
      if ({voice_active, voice_note, voice_trig, scan_idx} !== {exp_active, exp_note, exp_trig, exp_scan}) begin
        n_fail++;
        $display("FAIL scan_resume c%0d: act=%b note=%h trig=%b scan=%0d want act=%b note=%h trig=%b scan=%0d",
                 c, voice_active, voice_note, voice_trig, scan_idx, exp_active, exp_note, exp_trig, exp_scan);
      end
    end
  endtask

  task automatic test_async_reset;
    keys = '0;
    repeat (16) @(negedge clk);
    keys[10] = 1'b1; keys[11] = 1'b1; keys[12] = 1'b1;
    repeat (16) @(negedge clk);
    n_tests++;
    if (voice_active !== exp_active || $countones(voice_active) != 3) begin
      n_fail++;
      $display("FAIL arst_setup: act=%b want %b with 3 active", voice_active, exp_active);
    end
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    n_tests++;
    if ({voice_active, voice_note, voice_trig, scan_idx} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: act=%b note=%h trig=%b scan=%0d want zero",
               voice_active, voice_note, voice_trig, scan_idx);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_tests++;
      if ({voice_active, voice_note, voice_trig, scan_idx} !== {exp_active, exp_note, exp_trig, exp_scan}) begin
        n_fail++;
        $display("FAIL arst_realloc c%0d: act=%b note=%h trig=%b scan=%0d want act=%b note=%h trig=%b scan=%0d",
                 c, voice_active, voice_note, voice_trig, scan_idx, exp_active, exp_note, exp_trig, exp_scan);
      end
    end
    n_tests++;
    if (voice_active !== 4'b0111 || voice_note[11:0] !== 12'hCBA) begin
      n_fail++;
      $display("FAIL arst_order: act=%b note=%h want act=0111 note[11:0]=cba", voice_active, voice_note);
    end
  endtask

  task automatic test_random;
    int idx;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_tests++;
      if ({voice_active, voice_note, voice_trig, scan_idx} !== {exp_active, exp_note, exp_trig, exp_scan}) begin
        n_fail++;
        $display("FAIL random c%0d: act=%b note=%h trig=%b scan=%0d want act=%b note=%h trig=%b scan=%0d",
                 c, voice_active, voice_note, voice_trig, scan_idx, exp_active, exp_note, exp_trig, exp_scan);
      end
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, NK - 1);
        keys[idx] = ~keys[idx];
      end
      scan_en = ($urandom_range(0, 7) != 0);
`ifdef TMNT_SUSTAIN_EN
      if ($urandom_range(0, 63) == 0) sus = ~sus;
`endif
    end
    scan_en = 1'b1;
    sus = 1'b0;
  endtask

`ifdef TMNT_SUSTAIN_EN
  task automatic test_sustain;
    @(negedge clk);
    nrst = 1'b0; keys = '0; sus = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    keys[2] = 1'b1;
    repeat (16) @(negedge clk);
    n_tests++;
    if (voice_active !== 4'b0001 || voice_note[3:0] !== 4'd2) begin
      n_fail++;
      $display("FAIL sus_press: act=%b note0=%0d want act=0001 note0=2", voice_active, voice_note[3:0]);
    end
    sus = 1'b1;
    keys[2] = 1'b0;
    repeat (16) @(negedge clk);
    n_tests++;
    if (voice_active[0] !== 1'b1 || voice_active !== exp_active) begin
      n_fail++;
      $display("FAIL sus_hold: act=%b want 0001", voice_active);
    end
    sus = 1'b0;
    @(negedge clk);
    n_tests++;
    if (voice_active[0] !== 1'b0 || voice_active !== exp_active) begin
      n_fail++;
      $display("FAIL sus_release: act=%b want 0000", voice_active);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_steal();
    test_release();
    test_scan_hold();
    test_async_reset();
    test_random();
`ifdef TMNT_SUSTAIN_EN
    test_sustain();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
